// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin two-port byte arbiter that feeds a shared FIFO and
//               drains it into one UART TX. Optional send timeout is enabled by
//               defining UART_TX_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 1 << 20
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_p0_request,
    input  logic [31:0]                i_p0_wdata,
    output logic                       o_p0_ready,
    input  logic                       i_p1_request,
    input  logic [31:0]                i_p1_wdata,
    output logic                       o_p1_ready,
    output logic                       o_uart_request,
    output logic [31:0]                o_uart_wdata,
    input  logic                       i_uart_ready,
    output logic                       o_busy,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_error
);

    localparam int            AW         = $clog2(DEPTH);
    localparam int            LW         = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SEND    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          rr_q, rr_d;
    logic [1:0]    armed_q, armed_d;
    logic [1:0]    ready_q, ready_d;
    logic [1:0]    sync_q;
    logic          uart_req_q, uart_req_d;
    logic [7:0]    uart_byte_q, uart_byte_d;
    logic          error_q, error_d;

    logic          rdy_s;
    logic          fifo_full;
    logic          fifo_empty;
    logic [1:0]    req;
    logic [1:0]    elig;
    logic [1:0]    grant;
    logic          push;
    logic          pop;
    logic [7:0]    push_byte;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0]   cnt_q, cnt_d;
    logic          unused_bits;
    assign unused_bits = ^{i_p0_wdata[31:8], i_p1_wdata[31:8]};
`else
    logic          unused_bits;
    assign unused_bits = ^{i_p0_wdata[31:8], i_p1_wdata[31:8], TIMEOUT_CYCLES[0]};
`endif

    assign rdy_s      = sync_q[1];
    assign fifo_full  = (level_q == FULL_LEVEL);
    assign fifo_empty = (level_q == '0);
    assign req        = {i_p1_request, i_p0_request};

    // Full blocks grants even when the sequencer pops in the same cycle.
    assign elig     = req & armed_q & {2{~fifo_full}};
    assign grant[0] = elig[0] & (~elig[1] | ~rr_q);
    assign grant[1] = elig[1] & (~elig[0] |  rr_q);
    assign push     = |grant;
    assign push_byte = grant[1] ? i_p1_wdata[7:0] : i_p0_wdata[7:0];

    always_comb begin
        rr_d    = rr_q;
        armed_d = armed_q;
        ready_d = ready_q;
        if (grant[0]) rr_d = 1'b1;
        if (grant[1]) rr_d = 1'b0;
        for (int p = 0; p < 2; p++) begin
            if (!req[p]) begin
                armed_d[p] = 1'b1;
                ready_d[p] = 1'b0;
            end else if (grant[p]) begin
                armed_d[p] = 1'b0;
                ready_d[p] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        uart_req_d  = uart_req_q;
        uart_byte_d = uart_byte_q;
        error_d     = error_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
        cnt_d       = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    uart_byte_d = mem_q[rd_ptr_q];
                    uart_req_d  = 1'b1;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 32'd1;
`endif
                if (rdy_s) begin
                    uart_req_d = 1'b0;
                    state_d    = ST_RELEASE;
                end
`ifdef UART_TX_ARB_TIMEOUT_EN
                // The byte was already popped, so abandoning it here discards it.
                else if (cnt_q == TIMEOUT_LAST) begin
                    uart_req_d = 1'b0;
                    error_d    = 1'b1;
                    state_d    = ST_RELEASE;
                end
`endif
            end
            ST_RELEASE: begin
                if (!rdy_s) state_d = ST_IDLE;
            end
            default: begin
                uart_req_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (push) mem_q[wr_ptr_q] <= push_byte;
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            rr_q        <= 1'b0;
            armed_q     <= 2'b11;
            ready_q     <= 2'b00;
            sync_q      <= 2'b00;
            uart_req_q  <= 1'b0;
            uart_byte_q <= 8'h00;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            rr_q        <= rr_d;
            armed_q     <= armed_d;
            ready_q     <= ready_d;
            sync_q      <= {sync_q[0], i_uart_ready};
            uart_req_q  <= uart_req_d;
            uart_byte_q <= uart_byte_d;
            error_q     <= error_d;
        end
    end

`ifdef UART_TX_ARB_TIMEOUT_EN
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
    assign o_error = error_q;
`else
    assign o_error = 1'b0;
`endif

    assign o_p0_ready     = ready_q[0];
    assign o_p1_ready     = ready_q[1];
    assign o_uart_request = uart_req_q;
    assign o_uart_wdata   = {24'b0, uart_byte_q};
    assign o_busy         = ~fifo_empty | (state_q != ST_IDLE);
    assign o_level        = level_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        p0_req = 1'b0, p1_req = 1'b0, uart_rdy = 1'b0;
    logic [31:0] p0_wdata = '0, p1_wdata = '0;
    logic        p0_rdy, p1_rdy, uart_req, busy, err;
    logic [31:0] uart_wdata;
    logic [4:0]  level;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.DEPTH(16), .TIMEOUT_CYCLES(100)) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_p0_request  (p0_req),
        .i_p0_wdata    (p0_wdata),
        .o_p0_ready    (p0_rdy),
        .i_p1_request  (p1_req),
        .i_p1_wdata    (p1_wdata),
        .o_p1_ready    (p1_rdy),
        .o_uart_request(uart_req),
        .o_uart_wdata  (uart_wdata),
        .i_uart_ready  (uart_rdy),
        .o_busy        (busy),
        .o_level       (level),
        .o_error       (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        p0_req = 0; p1_req = 0; uart_rdy = 0;
        rst = 1;
        tick(); tick();
        rst = 0;
        tick();
    endtask

    task automatic push_p0(input logic [7:0] b);
        p0_req = 1; p0_wdata = {24'hABCDEF, b};
        tick();
        p0_req = 0;
        tick();
    endtask

    // Plays the UART side of one transfer; reports the byte seen and whether it completed.
    task automatic uart_take(output logic [7:0] b, output bit ok);
        ok = 0; b = 8'hxx;
        for (int i = 0; i < 300; i++) begin
            if (uart_req) begin ok = 1; break; end
            tick();
        end
        if (!ok) return;
        b = uart_wdata[7:0];
        uart_rdy = 1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!uart_req) begin ok = 1; break; end
        end
        uart_rdy = 0;
    endtask

    task automatic test_reset();
        rst = 1; #1;
        tick();
        n_checks++; if (uart_req !== 1'b0) begin n_fail++; $display("FAIL reset_uart_req got=%b want=0", uart_req); end
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL reset_level got=%0d want=0", level); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++; if ({p0_rdy, p1_rdy} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got=%b want=00", {p0_rdy, p1_rdy}); end
        n_checks++; if (uart_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got=%h want=0", uart_wdata); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b want=0", err); end
        rst = 0;
        tick();
    endtask

    task automatic test_single();
        logic [7:0] b; bit ok;
        p0_req = 1; p0_wdata = 32'h12345641;
        tick();
        n_checks++; if (p0_rdy !== 1'b1) begin n_fail++; $display("FAIL single_p0_ready got=%b want=1", p0_rdy); end
        n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL single_level got=%0d want=1", level); end
        p0_req = 0;
        tick();
        n_checks++; if (uart_req !== 1'b1) begin n_fail++; $display("FAIL single_uart_req got=%b want=1", uart_req); end
        n_checks++; if (uart_wdata !== 32'h41) begin n_fail++; $display("FAIL single_wdata got=%h want=00000041", uart_wdata); end
        n_checks++; if (p0_rdy !== 1'b0) begin n_fail++; $display("FAIL single_p0_ready_clear got=%b want=0", p0_rdy); end
        uart_take(b, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL single_handshake got=timeout want=drop"); end
        for (int i = 0; i < 10 && busy; i++) tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_after got=%b want=0", busy); end
    endtask

    task automatic test_both_rr();
        logic [7:0] b0, b1; bit ok0, ok1;
        do_reset();
        p0_req = 1; p0_wdata = 32'hA0;
        p1_req = 1; p1_wdata = 32'hB1;
        tick();
        n_checks++; if ({p1_rdy, p0_rdy} !== 2'b01) begin n_fail++; $display("FAIL rr_first got=%b want=01", {p1_rdy, p0_rdy}); end
        tick();
        n_checks++; if ({p1_rdy, p0_rdy} !== 2'b11) begin n_fail++; $display("FAIL rr_second got=%b want=11", {p1_rdy, p0_rdy}); end
        p0_req = 0; p1_req = 0;
        uart_take(b0, ok0);
        uart_take(b1, ok1);
        n_checks++; if (!ok0 || b0 !== 8'hA0) begin n_fail++; $display("FAIL rr_byte0 got=%h want=a0", b0); end
        n_checks++; if (!ok1 || b1 !== 8'hB1) begin n_fail++; $display("FAIL rr_byte1 got=%h want=b1", b1); end
    endtask

    task automatic test_hold_rearm();
        logic [7:0] b0, b1; bit ok0, ok1;
        p0_req = 1; p0_wdata = 32'h33;
        tick(); tick(); tick(); tick();
        n_checks++; if (p0_rdy !== 1'b1) begin n_fail++; $display("FAIL hold_ready got=%b want=1", p0_rdy); end
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL hold_no_rewrite got=%0d want=0", level); end
        p0_req = 0;
        tick();
        n_checks++; if (p0_rdy !== 1'b0) begin n_fail++; $display("FAIL hold_ready_drop got=%b want=0", p0_rdy); end
        p0_req = 1; p0_wdata = 32'h42;
        tick();
        n_checks++; if (level !== 5'd1) begin n_fail++; $display("FAIL hold_rearm_level got=%0d want=1", level); end
        p0_req = 0;
        uart_take(b0, ok0);
        uart_take(b1, ok1);
        n_checks++; if (!ok0 || b0 !== 8'h33) begin n_fail++; $display("FAIL hold_byte0 got=%h want=33", b0); end
        n_checks++; if (!ok1 || b1 !== 8'h42) begin n_fail++; $display("FAIL hold_byte1 got=%h want=42", b1); end
    endtask

    task automatic test_full();
        logic [7:0] b; bit ok; bit seen;
        // First byte lands in the sequencer, the next 16 fill the FIFO.
        for (int i = 0; i < 17; i++) push_p0(8'(8'h10 + i));
        n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL full_level got=%0d want=16", level); end
        p1_req = 1; p1_wdata = 32'hEE;
        tick(); tick(); tick();
        n_checks++; if (p1_rdy !== 1'b0) begin n_fail++; $display("FAIL full_blocks got=%b want=0", p1_rdy); end
        n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL full_level_hold got=%0d want=16", level); end
        uart_take(b, ok);
        n_checks++; if (!ok || b !== 8'h10) begin n_fail++; $display("FAIL full_byte_first got=%h want=10", b); end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (p1_rdy) begin seen = 1; break; end
            tick();
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL full_17th_accept got=0 want=1"); end
        p1_req = 0;
        for (int i = 0; i < 17; i++) begin
            uart_take(b, ok);
            n_checks++;
            if (!ok || b !== ((i == 16) ? 8'hEE : 8'(8'h11 + i))) begin
                n_fail++;
                $display("FAIL full_drain_%0d got=%h want=%h", i, b, (i == 16) ? 8'hEE : 8'(8'h11 + i));
            end
        end
        for (int i = 0; i < 10 && busy; i++) tick();
        n_checks++; if (level !== 5'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL full_drained got=%0d/%b want=0/0", level, busy); end
    endtask

    task automatic test_reset_mid_send();
        push_p0(8'h55);
        p0_req = 1; p0_wdata = 32'h66;
        tick();
        n_checks++; if (uart_req !== 1'b1 || level !== 5'd1 || p0_rdy !== 1'b1) begin n_fail++; $display("FAIL midrst_setup got=%b/%0d/%b want=1/1/1", uart_req, level, p0_rdy); end
        #2 rst = 1;
        #1;
        n_checks++; if (uart_req !== 1'b0) begin n_fail++; $display("FAIL midrst_req got=%b want=0", uart_req); end
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL midrst_level got=%0d want=0", level); end
        n_checks++; if (p0_rdy !== 1'b0) begin n_fail++; $display("FAIL midrst_ready got=%b want=0", p0_rdy); end
        p0_req = 0;
        tick();
        rst = 0;
        tick();
    endtask

    task automatic test_timeout();
`ifdef UART_TX_ARB_TIMEOUT_EN
        logic [7:0] b; bit ok; int hi;
        push_p0(8'h77);
        hi = 0;
        for (int i = 0; i < 300 && !uart_req; i++) tick();
        while (uart_req && hi < 300) begin tick(); hi++; end
        n_checks++; if (hi < 99 || hi > 102) begin n_fail++; $display("FAIL timeout_cycles got=%0d want=100", hi); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_error got=%b want=1", err); end
        push_p0(8'h78);
        uart_take(b, ok);
        n_checks++; if (!ok || b !== 8'h78) begin n_fail++; $display("FAIL timeout_next got=%h want=78", b); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky got=%b want=1", err); end
`else
        logic [7:0] b; bit ok;
        push_p0(8'h77);
        for (int i = 0; i < 150; i++) tick();
        n_checks++; if (uart_req !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL no_timeout got=%b/%b want=1/0", uart_req, err); end
        uart_take(b, ok);
        n_checks++; if (!ok || b !== 8'h77) begin n_fail++; $display("FAIL no_timeout_byte got=%h want=77", b); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_both_rr();
        test_hold_rearm();
        test_full();
        test_reset_mid_send();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
